rr_grant_encoder_4: RTL and testbench

Four-channel round-robin arbiter that sits directly upstream of `decoder_2x4`. It produces the registered 2-bit grant index on `I2`/`I1` and the grant-valid `En` that drive the decoder, so `O` becomes a one-hot grant vector. A grant is held until the owner releases it. An optional hold timeout revokes grants from stuck requesters.

---
 rtl/rr_grant_encoder_4_if.sv | 13 +
 rtl/rr_grant_encoder_4.sv | 136 +++++++++++++
 tb/tb_rr_grant_encoder_4.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/rr_grant_encoder_4_if.sv
// Request/grant bundle between the requesters and the round-robin grant encoder.
// master = requester side, slave = arbiter side.
interface rr_grant_encoder_4_if;
  logic [3:0] Req;
  logic       Ack;
  logic       I1;
  logic       I2;
  logic       En;
  logic       Timeout;

  modport master (output Req, Ack, input I1, I2, En, Timeout);
  modport slave  (input Req, Ack, output I1, I2, En, Timeout);
endinterface

// File: rtl/rr_grant_encoder_4.sv
// Four-channel round-robin arbiter producing a registered {I2,I1} grant index plus En for decoder_2x4.
// Optional hold timeout is compiled in with `define RR_GRANT_TIMEOUT_EN.

// Per-channel qualifier: flags requests at or above the priority pointer.
module rr_grant_lane #(
  parameter int LANE  = 0,
  parameter int IDX_W = 2
) (
  input  logic             req,
  input  logic [IDX_W-1:0] ptr,
  output logic             hi_req
);
  assign hi_req = req & (IDX_W'(LANE) >= ptr);
endmodule

module rr_grant_encoder_4 #(
  parameter int HOLD_MAX = 16
) (
  input logic            Clk,
  input logic            Rst_n,
  rr_grant_encoder_4_if.slave bus
);
  localparam int NUM_LANES = 4;
  localparam int IDX_W     = 2;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 en_q, en_d;
  logic [NUM_LANES-1:0] req, hi_req;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_vld;
  logic                 owner_req;
  logic                 expire;

  assign req = bus.Req;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    rr_grant_lane #(.LANE(g), .IDX_W(IDX_W)) u_lane (
      .req   (req[g]),
      .ptr   (ptr_q),
      .hi_req(hi_req[g])
    );
  end

  // Lowest requester at/above ptr wins; otherwise wrap to lowest requester overall.
  always_comb begin
    pick_idx = '0;
    for (int k = NUM_LANES - 1; k >= 0; k--)
      if (req[k]) pick_idx = IDX_W'(k);
    for (int k = NUM_LANES - 1; k >= 0; k--)
      if (hi_req[k]) pick_idx = IDX_W'(k);
  end

  assign pick_vld  = |req;
  assign owner_req = req[idx_q];

`ifdef RR_GRANT_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       to_q, to_d;

  // cnt_q counts GRANT edges survived; expiry lands on the HOLD_MAX-th edge of the grant.
  assign expire      = (cnt_q == 8'(HOLD_MAX - 1));
  assign bus.Timeout = to_q;
`else
  wire unused_hold_max = |8'(HOLD_MAX);
  assign expire      = 1'b0;
  assign bus.Timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    en_d    = en_q;
`ifdef RR_GRANT_TIMEOUT_EN
    cnt_d   = cnt_q;
    to_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          idx_d   = pick_idx;
          en_d    = 1'b1;
          state_d = GRANT;
`ifdef RR_GRANT_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      GRANT: begin
        if (bus.Ack || !owner_req || expire) begin
          en_d    = 1'b0;
          ptr_d   = idx_q + 1'b1;
          state_d = IDLE;
`ifdef RR_GRANT_TIMEOUT_EN
          to_d    = expire & ~bus.Ack;
`endif
        end else begin
`ifdef RR_GRANT_TIMEOUT_EN
          cnt_d   = cnt_q + 8'd1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      en_q    <= 1'b0;
`ifdef RR_GRANT_TIMEOUT_EN
      cnt_q   <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      en_q    <= en_d;
`ifdef RR_GRANT_TIMEOUT_EN
      cnt_q   <= cnt_d;
      to_q    <= to_d;
`endif
    end
  end

  assign bus.I1 = idx_q[0];
  assign bus.I2 = idx_q[1];
  assign bus.En = en_q;
endmodule

// File: tb/tb_rr_grant_encoder_4.sv
// Bench for rr_grant_encoder_4: directed vectors with literal expectations plus a
// cycle-level reference model compared on every falling clock edge.
module tb_rr_grant_encoder_4;
  localparam int HOLD = 4;
`ifdef RR_GRANT_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic Clk   = 1'b0;
  logic Rst_n = 1'b0;

  rr_grant_encoder_4_if bus();

  rr_grant_encoder_4 #(.HOLD_MAX(HOLD)) dut (
    .Clk  (Clk),
    .Rst_n(Rst_n),
    .bus  (bus)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: m_held = number of cycles En has been high in the current grant.
  int         m_ptr, m_own, m_held;
  bit         m_gnt;
  logic       m_en, m_to;
  logic [1:0] m_idx;

  always @(posedge Clk or negedge Rst_n) begin : model
    int         nptr, nown, nheld;
    bit         ngnt, found, ack, drop, expire;
    logic       nen, nto;
    logic [1:0] nidx;
    if (!Rst_n) begin
      m_ptr  <= 0;
      m_own  <= 0;
      m_held <= 0;
      m_gnt  <= 1'b0;
      m_en   <= 1'b0;
      m_to   <= 1'b0;
      m_idx  <= 2'd0;
    end else begin
      nptr  = m_ptr;
      nown  = m_own;
      nheld = m_held;
      ngnt  = m_gnt;
      nen   = m_en;
      nidx  = m_idx;
      nto   = 1'b0;
      if (!m_gnt) begin
        found = 1'b0;
        for (int k = 0; k < 4; k++)
          if (!found && bus.Req[(m_ptr + k) % 4]) begin
            found = 1'b1;
            nown  = (m_ptr + k) % 4;
          end
        if (found) begin
          ngnt  = 1'b1;
          nen   = 1'b1;
          nidx  = 2'(nown);
          nheld = 1;
        end
      end else begin
        ack    = bus.Ack;
        drop   = !bus.Req[m_own];
        expire = TO_EN && (m_held >= HOLD);
        if (ack || drop || expire) begin
          ngnt = 1'b0;
          nen  = 1'b0;
          nptr = (m_own + 1) % 4;
          nto  = expire && !ack;
        end else begin
          nheld = m_held + 1;
        end
      end
      m_ptr  <= nptr;
      m_own  <= nown;
      m_held <= nheld;
      m_gnt  <= ngnt;
      m_en   <= nen;
      m_to   <= nto;
      m_idx  <= nidx;
    end
  end

  always @(negedge Clk) begin
    check("model_en",  8'(bus.En),             8'(m_en));
    check("model_idx", 8'({bus.I2, bus.I1}),   8'(m_idx));
    check("model_to",  8'(bus.Timeout),        8'(m_to));
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic en, input logic [1:0] idx);
    check({name, "_en"}, 8'(bus.En), 8'(en));
    if (en) check({name, "_idx"}, 8'({bus.I2, bus.I1}), 8'(idx));
  endtask

  initial begin
    bus.Req = 4'b1111;
    bus.Ack = 1'b0;
    Rst_n   = 1'b0;
    tick(2);
    check("rst_en",  8'(bus.En), 8'd0);
    check("rst_idx", 8'({bus.I2, bus.I1}), 8'd0);
    check("rst_to",  8'(bus.Timeout), 8'd0);
    Rst_n = 1'b1;
    tick();
    expect_out("first_grant", 1'b1, 2'd0);
    bus.Ack = 1'b1; tick();
    expect_out("first_rel", 1'b0, 2'd0);
    bus.Ack = 1'b0; bus.Req = 4'b0000; tick();
    expect_out("idle_noreq", 1'b0, 2'd0);
    check("idle_idx_hold", 8'({bus.I2, bus.I1}), 8'd0);

    // single request, then ptr=3 shows up as ch3 beating ch0
    bus.Req = 4'b0100; tick();
    expect_out("single", 1'b1, 2'd2);
    bus.Ack = 1'b1; tick();
    expect_out("single_rel", 1'b0, 2'd0);
    check("idle_idx_keep", 8'({bus.I2, bus.I1}), 8'd2);
    bus.Ack = 1'b0; bus.Req = 4'b1001; tick();
    expect_out("ptr3", 1'b1, 2'd3);
    bus.Ack = 1'b1; tick();
    expect_out("ptr3_rel", 1'b0, 2'd0);
    bus.Ack = 1'b0; bus.Req = 4'b1111;

    // fairness: 00,01,10,11,00 with a gap cycle after each
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_out("fair", 1'b1, 2'(i % 4));
      bus.Ack = 1'b1; tick();
      expect_out("fair_gap", 1'b0, 2'd0);
      bus.Ack = 1'b0;
    end

    // wrap and withdrawal
    bus.Req = 4'b0100; tick();
    expect_out("wrap_g2", 1'b1, 2'd2);
    bus.Ack = 1'b1; tick();
    bus.Ack = 1'b0; bus.Req = 4'b0101; tick();
    expect_out("wrap_g0", 1'b1, 2'd0);
    bus.Req = 4'b0100; tick();
    expect_out("withdraw", 1'b0, 2'd0);
    tick();
    expect_out("after_withdraw", 1'b1, 2'd2);
    bus.Req = 4'b0000; tick();
    expect_out("drop2", 1'b0, 2'd0);

`ifdef RR_GRANT_TIMEOUT_EN
    bus.Req = 4'b0010; tick();
    expect_out("to_c1", 1'b1, 2'd1);
    for (int c = 2; c <= HOLD; c++) begin
      tick();
      expect_out("to_hold", 1'b1, 2'd1);
      check("to_hold_pulse", 8'(bus.Timeout), 8'd0);
    end
    tick();
    expect_out("to_expire", 1'b0, 2'd0);
    check("to_pulse", 8'(bus.Timeout), 8'd1);
    tick();
    expect_out("to_regrant", 1'b1, 2'd1);
    check("to_pulse_once", 8'(bus.Timeout), 8'd0);
    for (int c = 2; c <= HOLD; c++) tick();
    expect_out("to_c4", 1'b1, 2'd1);
    bus.Ack = 1'b1; tick();
    expect_out("ack_wins", 1'b0, 2'd0);
    check("ack_wins_to", 8'(bus.Timeout), 8'd0);
    bus.Ack = 1'b0; bus.Req = 4'b0000; tick();
`else
    bus.Req = 4'b0010; tick();
    expect_out("nto_grant", 1'b1, 2'd1);
    for (int c = 0; c < 300; c++) begin
      tick();
      check("nto_en", 8'(bus.En), 8'd1);
      check("nto_to", 8'(bus.Timeout), 8'd0);
    end
    bus.Ack = 1'b1; tick();
    expect_out("nto_rel", 1'b0, 2'd0);
    bus.Ack = 1'b0; bus.Req = 4'b0000; tick();
`endif

    // async reset between edges while granted
    bus.Req = 4'b0010; tick();
    expect_out("pre_arst", 1'b1, 2'd1);
    #2 Rst_n = 1'b0;
    #1;
    check("arst_en",  8'(bus.En), 8'd0);
    check("arst_idx", 8'({bus.I2, bus.I1}), 8'd0);
    check("arst_to",  8'(bus.Timeout), 8'd0);
    bus.Req = 4'b1000; tick();
    check("arst_hold_en", 8'(bus.En), 8'd0);
    Rst_n = 1'b1; tick();
    expect_out("post_arst", 1'b1, 2'd3);
    bus.Ack = 1'b1; tick();
    expect_out("post_arst_rel", 1'b0, 2'd0);
    bus.Ack = 1'b0; bus.Req = 4'b0000;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
